// File: rtl/key_debounce_pkg.sv
// Shared definitions for the pushbutton conditioner: FSM encoding,
// pressed-level constant and the ms-to-cycles helper.
package key_pkg;

  typedef enum logic [1:0] {
    UP      = 2'd0,
    WAIT_DN = 2'd1,
    DOWN    = 2'd2,
    WAIT_UP = 2'd3
  } key_state_e;

  localparam logic KEY_PRESSED = 1'b0;

  function automatic int unsigned ms_to_cycles(input int unsigned clk_hz,
                                               input int unsigned ms);
    return (clk_hz / 1000) * ms;
  endfunction

endpackage

// File: rtl/key_debounce_ch.sv
// One pushbutton channel: 2-FF synchroniser, debounce FSM, registered
// level plus press / release / long-press pulses.
module key_debounce_ch
  import key_pkg::*;
#(
  parameter int unsigned CLK_HZ      = 50_000_000,
  parameter int unsigned DEBOUNCE_MS = 20,
  parameter int unsigned LONG_MS     = 1000
) (
  input  logic clk_50,
  input  logic rst_n,
  input  logic key_raw,
  output logic level_o,
  output logic press_o,
  output logic release_o,
  output logic long_o
);

  localparam int unsigned DEB_CYC  = ms_to_cycles(CLK_HZ, DEBOUNCE_MS);
  localparam int unsigned LONG_CYC = ms_to_cycles(CLK_HZ, LONG_MS);
  localparam int CNT_W  = $clog2(DEB_CYC) + 1;
  localparam int HOLD_W = $clog2(LONG_CYC) + 1;
  localparam logic [CNT_W-1:0]  DEB_LAST  = CNT_W'(DEB_CYC - 1);
  localparam logic [HOLD_W-1:0] LONG_LAST = HOLD_W'(LONG_CYC - 1);
  localparam logic [HOLD_W-1:0] LONG_MAX  = HOLD_W'(LONG_CYC);

  generate
    if (DEB_CYC < 1 || LONG_CYC < 1) begin : g_bad_params
      $error("key_debounce_ch: DEB_CYC and LONG_CYC must both be >= 1");
    end
  endgenerate

  key_state_e        state_q, state_d;
  logic [CNT_W-1:0]  cnt_q, cnt_d;
  logic [HOLD_W-1:0] hold_q, hold_d, hold_inc;
  logic              sync1_q, sync1_d, sync2_q, sync2_d;
  logic              level_q, level_d;
  logic              press_q, press_d;
  logic              release_q, release_d;
  logic              long_q, long_d;
  logic              s;

  // s is the only view of the pin the FSM ever sees
  assign s = (sync2_q == KEY_PRESSED);

  always_comb begin
    sync1_d   = key_raw;
    sync2_d   = sync1_q;
    state_d   = state_q;
    cnt_d     = cnt_q;
    hold_d    = hold_q;
    hold_inc  = hold_q + 1'b1;
    level_d   = level_q;
    press_d   = 1'b0;
    release_d = 1'b0;
    long_d    = 1'b0;
    case (state_q)
      UP: begin
        if (s) begin
          state_d = WAIT_DN;
          cnt_d   = '0;
        end
      end
      WAIT_DN: begin
        if (!s) begin
          state_d = UP;
        end else if (cnt_q == DEB_LAST) begin
          state_d = DOWN;
          level_d = 1'b1;
          press_d = 1'b1;
          hold_d  = '0;
        end else begin
          cnt_d = cnt_q + 1'b1;
        end
      end
      DOWN: begin
        if (!s) begin
          state_d = WAIT_UP;
          cnt_d   = '0;
        end else if (hold_q != LONG_MAX) begin
          // hold never returns below LONG_LAST, so the long pulse fires once per press
          hold_d = hold_inc;
          long_d = (hold_inc == LONG_LAST);
        end
      end
      WAIT_UP: begin
        if (s) begin
          state_d = DOWN;
        end else if (cnt_q == DEB_LAST) begin
          state_d   = UP;
          level_d   = 1'b0;
          release_d = 1'b1;
        end else begin
          cnt_d = cnt_q + 1'b1;
        end
      end
      default: state_d = UP;
    endcase
  end

  always_ff @(posedge clk_50 or negedge rst_n) begin
    if (!rst_n) begin
      sync1_q   <= 1'b1;
      sync2_q   <= 1'b1;
      state_q   <= UP;
      cnt_q     <= '0;
      hold_q    <= '0;
      level_q   <= 1'b0;
      press_q   <= 1'b0;
      release_q <= 1'b0;
      long_q    <= 1'b0;
    end else begin
      sync1_q   <= sync1_d;
      sync2_q   <= sync2_d;
      state_q   <= state_d;
      cnt_q     <= cnt_d;
      hold_q    <= hold_d;
      level_q   <= level_d;
      press_q   <= press_d;
      release_q <= release_d;
      long_q    <= long_d;
    end
  end

  assign level_o   = level_q;
  assign press_o   = press_q;
  assign release_o = release_q;
  assign long_o    = long_q;

endmodule

// File: rtl/key_debounce.sv
// Pushbutton conditioner top: N_KEYS independent debounce channels on clk_50.
module key_debounce
  import key_pkg::*;
#(
  parameter int unsigned N_KEYS      = 4,
  parameter int unsigned CLK_HZ      = 50_000_000,
  parameter int unsigned DEBOUNCE_MS = 20,
  parameter int unsigned LONG_MS     = 1000
) (
  input  logic              clk_50,
  input  logic              rst_n,
  input  logic [N_KEYS-1:0] KEY,
  output logic [N_KEYS-1:0] key_level,
  output logic [N_KEYS-1:0] key_press,
  output logic [N_KEYS-1:0] key_release,
  output logic [N_KEYS-1:0] key_long
);

  for (genvar i = 0; i < N_KEYS; i++) begin : g_ch
    key_debounce_ch #(
      .CLK_HZ      (CLK_HZ),
      .DEBOUNCE_MS (DEBOUNCE_MS),
      .LONG_MS     (LONG_MS)
    ) u_ch (
      .clk_50    (clk_50),
      .rst_n     (rst_n),
      .key_raw   (KEY[i]),
      .level_o   (key_level[i]),
      .press_o   (key_press[i]),
      .release_o (key_release[i]),
      .long_o    (key_long[i])
    );
  end

endmodule

// File: tb/tb_key_debounce.sv
// Scoreboard bench for key_debounce: stimulus pushes expected pulse events,
// a negedge monitor pops and compares them against the DUT outputs.
module tb_key_debounce;

  logic       clk_50 = 1'b0;
  logic       rst_n  = 1'b0;
  logic [3:0] KEY    = 4'hF;
  logic [3:0] key_level, key_press, key_release, key_long;

  key_debounce #(
    .N_KEYS      (4),
    .CLK_HZ      (1000),
    .DEBOUNCE_MS (5),
    .LONG_MS     (20)
  ) dut (
    .clk_50      (clk_50),
    .rst_n       (rst_n),
    .KEY         (KEY),
    .key_level   (key_level),
    .key_press   (key_press),
    .key_release (key_release),
    .key_long    (key_long)
  );

  always #5 clk_50 = ~clk_50;

  typedef struct {
    int         cyc;
    logic [3:0] pr;
    logic [3:0] rl;
    logic [3:0] lg;
  } ev_t;

  ev_t exp_q[$];
  int  cyc     = 0;
  int  n_tests = 0;
  int  n_fail  = 0;

  always @(posedge clk_50) cyc <= cyc + 1;

  function automatic void push(input int c, input logic [3:0] pr,
                               input logic [3:0] rl, input logic [3:0] lg);
    ev_t e;
    e.cyc = c; e.pr = pr; e.rl = rl; e.lg = lg;
    exp_q.push_back(e);
  endfunction

  task automatic tick(input int n);
    repeat (n) @(posedge clk_50);
    #1;
  endtask

  task automatic chk(input string name, input logic [3:0] act, input logic [3:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s at cycle %0d: got %b expected %b", name, cyc, act, exp);
    end
  endtask

  // Monitor: outputs are sampled on the falling edge, away from the active edge
  always @(negedge clk_50) begin
    if (!rst_n) begin
      n_tests++;
      if ({key_level, key_press, key_release, key_long} !== 16'h0) begin
        n_fail++;
        $display("FAIL reset_outputs at cycle %0d: got lvl=%b pr=%b rl=%b lg=%b expected all 0",
                 cyc, key_level, key_press, key_release, key_long);
      end
    end else begin
      while (exp_q.size() > 0 && exp_q[0].cyc < cyc) begin
        n_tests++;
        n_fail++;
        $display("FAIL missed_event: expected pr=%b rl=%b lg=%b at cycle %0d, still absent at cycle %0d",
                 exp_q[0].pr, exp_q[0].rl, exp_q[0].lg, exp_q[0].cyc, cyc);
        void'(exp_q.pop_front());
      end
      if ((key_press | key_release | key_long) !== 4'h0) begin
        n_tests++;
        if (exp_q.size() == 0 || exp_q[0].cyc != cyc) begin
          n_fail++;
          $display("FAIL unexpected_pulse at cycle %0d: got pr=%b rl=%b lg=%b expected no pulse",
                   cyc, key_press, key_release, key_long);
        end else begin
          if (key_press !== exp_q[0].pr || key_release !== exp_q[0].rl ||
              key_long !== exp_q[0].lg) begin
            n_fail++;
            $display("FAIL pulse_value at cycle %0d: got pr=%b rl=%b lg=%b expected pr=%b rl=%b lg=%b",
                     cyc, key_press, key_release, key_long,
                     exp_q[0].pr, exp_q[0].rl, exp_q[0].lg);
          end
          void'(exp_q.pop_front());
        end
      end
    end
  end

  initial begin
    int c;
    int r;

    // Reset held with random key activity
    rst_n = 1'b0;
    for (int i = 0; i < 8; i++) begin
      KEY = 4'($urandom_range(0, 15));
      tick(1);
    end
    KEY = 4'hF;
    tick(1);
    rst_n = 1'b1;
    tick(100);
    chk("idle_level", key_level, 4'b0000);

    // Clean press and release on key 0
    c = cyc;
    KEY[0] = 1'b0;
    push(c + 8, 4'b0001, 4'b0000, 4'b0000);
    tick(7);
    chk("k0_level_before", key_level, 4'b0000);
    tick(1);
    chk("k0_level_after", key_level, 4'b0001);
    tick(5);
    c = cyc;
    KEY[0] = 1'b1;
    push(c + 8, 4'b0000, 4'b0001, 4'b0000);
    tick(10);
    chk("k0_released", key_level, 4'b0000);

    // Bounce on key 1, then a real press
    KEY[1] = 1'b0; tick(3);
    KEY[1] = 1'b1; tick(2);
    KEY[1] = 1'b0; tick(4);
    KEY[1] = 1'b1; tick(10);
    chk("k1_bounce_level", key_level, 4'b0000);
    c = cyc;
    KEY[1] = 1'b0;
    push(c + 8, 4'b0010, 4'b0000, 4'b0000);
    tick(10);
    chk("k1_level", key_level, 4'b0010);
    KEY[1] = 1'b1;
    push(c + 18, 4'b0000, 4'b0010, 4'b0000);
    tick(12);

    // Long press on key 2
    c = cyc;
    KEY[2] = 1'b0;
    push(c + 8,  4'b0100, 4'b0000, 4'b0000);
    push(c + 27, 4'b0000, 4'b0000, 4'b0100);
    tick(30);
    chk("k2_held_level", key_level, 4'b0100);
    tick(10);
    KEY[2] = 1'b1;
    push(c + 48, 4'b0000, 4'b0100, 4'b0000);
    tick(12);
    chk("k2_released", key_level, 4'b0000);

    // Release bounce during hold on key 3: hold freezes for the bounce
    c = cyc;
    KEY[3] = 1'b0;
    push(c + 8,  4'b1000, 4'b0000, 4'b0000);
    push(c + 31, 4'b0000, 4'b0000, 4'b1000);
    tick(10);
    KEY[3] = 1'b1; tick(3);
    KEY[3] = 1'b0; tick(27);
    chk("k3_level_kept", key_level, 4'b1000);
    KEY[3] = 1'b1;
    push(c + 48, 4'b0000, 4'b1000, 4'b0000);
    tick(12);

    // Simultaneous events on keys 0 and 1
    c = cyc;
    KEY = 4'b1100;
    push(c + 8, 4'b0011, 4'b0000, 4'b0000);
    tick(10);
    chk("k01_level", key_level, 4'b0011);
    KEY = 4'hF;
    push(c + 18, 4'b0000, 4'b0011, 4'b0000);
    tick(12);

    // Reset during WAIT_DN discards the pending press
    KEY[0] = 1'b0;
    tick(4);
    rst_n = 1'b0;
    #1;
    chk("rst_wait_dn_level", key_level, 4'b0000);
    KEY[0] = 1'b1;
    tick(3);
    rst_n = 1'b1;
    tick(20);
    chk("after_rst_wait_dn", key_level, 4'b0000);

    // Reset during DOWN clears outputs at once; held key becomes a new press
    c = cyc;
    KEY[0] = 1'b0;
    push(c + 8, 4'b0001, 4'b0000, 4'b0000);
    tick(12);
    chk("k0_down_level", key_level, 4'b0001);
    rst_n = 1'b0;
    #1;
    chk("async_rst_level", key_level, 4'b0000);
    tick(3);
    r = cyc;
    rst_n = 1'b1;
    push(r + 8, 4'b0001, 4'b0000, 4'b0000);
    tick(10);
    chk("held_through_rst", key_level, 4'b0001);
    c = cyc;
    KEY[0] = 1'b1;
    push(c + 8, 4'b0000, 4'b0001, 4'b0000);
    tick(12);
    chk("final_level", key_level, 4'b0000);

    tick(5);
    n_tests++;
    if (exp_q.size() != 0) begin
      n_fail++;
      $display("FAIL pending_events: got %0d left expected 0", exp_q.size());
    end

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
